// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies finish in PREP on a single-cycle multiplier.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        DONE
    } state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic                neg_a;
    logic                neg_b;
    logic [2*XLEN-1:0]   acc;
    logic [CNT_W-1:0]    cnt;

    // Sign correction and result selection applied when an iterative op completes.
    function automatic logic [XLEN-1:0] finalize(
        input logic [2:0]        op,
        input logic [2*XLEN-1:0] raw,
        input logic              sa,
        input logic              sb
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = (sa ^ sb) ? -raw : raw;
        quo  = (sa ^ sb) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        rem  = sa ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        case (op)
            OP_MUL:                       finalize = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: finalize = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              finalize = quo;
            default:                      finalize = rem;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic neg, input logic [XLEN-1:0] v);
        abs_val = neg ? -v : v;
    endfunction

    assign busy_o = (state != IDLE);

    // PREP decode: which operands are signed, and the early-exit special cases
    logic            sgn_a_en;
    logic            sgn_b_en;
    logic            sa_prep;
    logic            sb_prep;
    logic            is_div;
    logic            is_rem;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        sgn_a_en = 1'b0;
        sgn_b_en = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn_a_en = 1'b1;
                sgn_b_en = 1'b1;
            end
            OP_MULHSU: sgn_a_en = 1'b1;
            default: ;
        endcase
    end

    assign sa_prep  = sgn_a_en & a_q[XLEN-1];
    assign sb_prep  = sgn_b_en & b_q[XLEN-1];
    assign is_div   = op_q[2];
    assign is_rem   = op_q[1];
    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem ? a_q : '1;
        else if (div_ovf)
            special_res = is_rem ? '0 : a_q;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;

    // Operands widened by one sign bit so MULHSU/MULHU fall out of one signed multiply.
    always_comb begin
        logic signed [XLEN:0] ext_a;
        logic signed [XLEN:0] ext_b;
        ext_a     = {sgn_a_en & a_q[XLEN-1], a_q};
        ext_b     = {sgn_b_en & b_q[XLEN-1], b_q};
        fast_prod = (2*XLEN)'(ext_a) * (2*XLEN)'(ext_b);
    end
`endif

    // CALC datapath: one multiply or one divide step per cycle, sharing acc
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        acc_next = is_div ? div_next : mul_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q  <= op_i;
                        a_q   <= rs1_i;
                        b_q   <= rs2_i;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (div_zero || div_ovf) begin
                        result_o <= special_res;
                        done_o   <= 1'b1;
                        state    <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        result_o <= finalize(op_q, fast_prod, 1'b0, 1'b0);
                        done_o   <= 1'b1;
                        state    <= DONE;
`endif
                    end else begin
                        // From here on a_q/b_q hold magnitudes; the signs live in neg_a/neg_b.
                        a_q   <= abs_val(sa_prep, a_q);
                        b_q   <= abs_val(sb_prep, b_q);
                        neg_a <= sa_prep;
                        neg_b <= sb_prep;
                        acc   <= is_div ? {{XLEN{1'b0}}, abs_val(sa_prep, a_q)}
                                        : {{XLEN{1'b0}}, abs_val(sb_prep, b_q)};
                        cnt   <= CNT_W'(XLEN);
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            result_o <= finalize(op_q, acc_next, neg_a, neg_b);
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed M-extension vectors, random ops
// against a 64-bit arithmetic reference, flush, ignored start, and mid-operation reset.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 2;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return XLEN + 2;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return XLEN + 2;
`endif
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op in the current cycle (cycle 0) and follow it to done_o and one cycle beyond.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string name);
        int          exp_lat;
        int          done_cyc;
        logic [31:0] got;
        bit          busy_bad;
        exp_lat = ref_latency(op, a, b);
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        start_i = 1'b1;
        step();
        start_i  = 1'b0;
        op_i     = 3'($urandom);
        rs1_i    = $urandom;
        rs2_i    = $urandom;
        done_cyc = -1;
        busy_bad = 1'b0;
        got      = '0;
        for (int c = 1; c <= 60; c++) begin
            if (busy_o !== 1'b1) busy_bad = 1'b1;
            if (done_o === 1'b1) begin
                done_cyc = c;
                got      = result_o;
                break;
            end
            step();
        end
        checks++;
        if (done_cyc != exp_lat) begin
            failures++;
            $display("FAIL %s latency: done_o in cycle %0d, required cycle %0d", name, done_cyc, exp_lat);
        end
        checks++;
        if (got !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %h, required %h (op=%0d a=%h b=%h)", name, got, exp_res, op, a, b);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL %s busy: busy_o was 0 before done_o, required 1 in cycles 1..done", name);
        end
        step();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done_o=%b busy_o=%b, required 0 0", name, done_o, busy_o);
        end
        last_res = exp_res;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        rs1_i   = '0;
        rs2_i   = '0;
        step();
        step();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
        checks++;
        if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done_o); end
        checks++;
        if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h, required 0", result_o); end
        rst_n = 1'b1;
        step();
        last_res = 32'h0;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "mulh_-2x3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7%2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100/7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100%7");
        run_op(3'd5, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(3'd6, 32'h0000_1234, 32'h0, 32'h0000_1234, "rem_by_zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_overflow");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_op(op, a, b, ref_model(op, a, b), "random");
        end
    endtask

    task automatic test_flush();
        bit saw_done;
        saw_done = 1'b0;
        op_i    = 3'd5;
        rs1_i   = 32'd1000;
        rs2_i   = 32'd3;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done_o === 1'b1) saw_done = 1'b1;
            step();
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy: busy_o=%b in cycle 11, required 0", busy_o); end
        checks++;
        if (result_o !== last_res) begin failures++; $display("FAIL flush_result: got %h, required %h", result_o, last_res); end
        for (int c = 0; c < 40; c++) begin
            if (done_o === 1'b1) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done) begin failures++; $display("FAIL flush_no_done: done_o pulsed=1, required 0"); end
    endtask

    task automatic test_start_ignored();
        int          ndone;
        int          first;
        logic [31:0] got;
        ndone = 0;
        first = -1;
        got   = '0;
        op_i    = 3'd5;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 5; c++) step();
        op_i    = 3'd0;
        rs1_i   = 32'd6;
        rs2_i   = 32'd7;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 6; c <= 80; c++) begin
            if (done_o === 1'b1) begin
                ndone++;
                if (first < 0) begin first = c; got = result_o; end
            end
            step();
        end
        checks++;
        if (ndone != 1) begin failures++; $display("FAIL ignore_start_count: %0d done pulses, required 1", ndone); end
        checks++;
        if (first != XLEN + 2) begin failures++; $display("FAIL ignore_start_latency: cycle %0d, required %0d", first, XLEN + 2); end
        checks++;
        if (got !== 32'd14) begin failures++; $display("FAIL ignore_start_result: got %h, required %h", got, 32'd14); end
        last_res = 32'd14;
    endtask

    task automatic test_flush_start_idle();
        bit saw_done;
        saw_done = 1'b0;
        op_i    = 3'd5;
        rs1_i   = 32'd5;
        rs2_i   = 32'd1;
        start_i = 1'b1;
        flush_i = 1'b1;
        step();
        start_i = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_start_busy: busy_o=%b, required 0", busy_o); end
        for (int c = 0; c < 40; c++) begin
            if (done_o === 1'b1) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done) begin failures++; $display("FAIL flush_start_done: done_o pulsed=1, required 0"); end
    endtask

    task automatic test_reset_mid();
        op_i    = 3'd0;
        rs1_i   = 32'h0000_1234;
        rs2_i   = 32'h0000_5678;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 15; c++) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b, required 0", busy_o); end
        checks++;
        if (result_o !== 32'h0) begin failures++; $display("FAIL midreset_result: got %h, required 0", result_o); end
        checks++;
        if (done_o !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b, required 0", done_o); end
        rst_n    = 1'b1;
        last_res = 32'h0;
        run_op(3'd0, 32'd6, 32'd7, 32'd42, "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_start_ignored();
        test_flush_start_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
